// File: rtl/vga_debug_pkg.sv
// vga_debug_pkg: view-mode encodings, drop counter width and address sizing shared by
// vga_multi_debug and its testbench.
package vga_debug_pkg;
    typedef enum logic [1:0] {
        MODE_SINGLE = 2'd0,
        MODE_SIDE   = 2'd1,
        MODE_TILE   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_t;
    localparam int DROP_W = 16;
    function automatic int addr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/sdp_ram_1clk.sv
// sdp_ram_1clk: single-clock simple dual-port RAM, registered read, old data on read-during-write.
module sdp_ram_1clk #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] q
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        q <= mem[ra];
    end
endmodule

// File: rtl/vga_multi_debug.sv
// vga_multi_debug: multi-channel debug frame store with SINGLE/SIDE/TILE display reads.
// Define VGA_DBG_STATS_EN to add per-channel saturating drop counters (drop_cnt port).
module vga_multi_debug
    import vga_debug_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int W     = 320,
    parameter int H     = 240,
    parameter int PIX_W = 8,
    parameter int XY_W  = 10,
    parameter logic [PIX_W-1:0] BORDER = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CH-1:0]      in_valid,
    output logic [N_CH-1:0]      in_ready,
    input  logic [N_CH*XY_W-1:0] in_x,
    input  logic [N_CH*XY_W-1:0] in_y,
    input  logic [N_CH*PIX_W-1:0] in_val,
    input  logic                 rd_en,
    input  logic [XY_W-1:0]      pixel_x,
    input  logic [XY_W-1:0]      pixel_y,
    input  logic [1:0]           mode,
    input  logic [1:0]           sel,
    output logic                 pixel_valid,
    output logic [PIX_W-1:0]     pixel_val
`ifdef VGA_DBG_STATS_EN
    ,
    output logic [N_CH*DROP_W-1:0] drop_cnt
`endif
);
    localparam int AW = addr_w(N_CH * W * H);
    localparam logic [XY_W:0]   WL = (XY_W+1)'(W);
    localparam logic [XY_W:0]   HL = (XY_W+1)'(H);
    localparam logic [XY_W:0]   W2 = (XY_W+1)'(2 * W);
    localparam logic [XY_W:0]   H2 = (XY_W+1)'(2 * H);
    localparam logic [XY_W-1:0] WS = XY_W'(W);
    localparam logic [XY_W-1:0] HS = XY_W'(H);

    function automatic logic [AW-1:0] addr(input logic [1:0] c, input logic [XY_W-1:0] x, input logic [XY_W-1:0] y);
        return AW'(c) * AW'(W * H) + AW'(y) * AW'(W) + AW'(x);
    endfunction

    logic [N_CH-1:0]  hv;
    logic [XY_W-1:0]  hx [N_CH];
    logic [XY_W-1:0]  hy [N_CH];
    logic [PIX_W-1:0] hd [N_CH];
    logic [1:0]       ptr, gnt;
    logic             gnt_v, in_img, we;
    logic [XY_W-1:0]  gx, gy;
    logic [PIX_W-1:0] gd, q;

    assign in_ready = ~hv;

    // Round-robin search starts at ptr, the channel after the previous grant.
    always_comb begin
        gnt_v = 1'b0;
        gnt = '0;
        gx = '0;
        gy = '0;
        gd = '0;
        for (int i = 0; i < N_CH; i++)
            for (int c = 0; c < N_CH; c++)
                if (!gnt_v && hv[c] && (int'(ptr) + i) % N_CH == c) begin
                    gnt_v = 1'b1;
                    gnt = 2'(c);
                end
        for (int c = 0; c < N_CH; c++)
            if (gnt == 2'(c)) begin
                gx = hx[c];
                gy = hy[c];
                gd = hd[c];
            end
        in_img = {1'b0, gx} < WL && {1'b0, gy} < HL;
        we = gnt_v && in_img;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hv <= '0;
            ptr <= '0;
            for (int c = 0; c < N_CH; c++) begin
                hx[c] <= '0;
                hy[c] <= '0;
                hd[c] <= '0;
            end
        end else begin
            if (gnt_v) ptr <= (gnt == 2'(N_CH - 1)) ? 2'd0 : gnt + 2'd1;
            for (int c = 0; c < N_CH; c++) begin
                if (gnt_v && gnt == 2'(c)) hv[c] <= 1'b0;
                else if (in_valid[c] && !hv[c]) begin
                    hv[c] <= 1'b1;
                    hx[c] <= in_x[c*XY_W +: XY_W];
                    hy[c] <= in_y[c*XY_W +: XY_W];
                    hd[c] <= in_val[c*PIX_W +: PIX_W];
                end
            end
        end
    end

    logic [1:0]      rc;
    logic [XY_W-1:0] rx, ry;
    logic            xa, ya, oob;

    always_comb begin
        xa = {1'b0, pixel_x} >= WL;
        ya = {1'b0, pixel_y} >= HL;
        rc = sel;
        rx = pixel_x;
        ry = pixel_y;
        oob = 1'b1;
        if (mode == MODE_SINGLE) oob = xa || ya;
        else if (mode == MODE_SIDE) begin
            rc = xa ? ((sel == 2'(N_CH - 1)) ? 2'd0 : sel + 2'd1) : sel;
            rx = xa ? pixel_x - WS : pixel_x;
            oob = ya || {1'b0, pixel_x} >= W2;
        end else if (mode == MODE_TILE) begin
            rc = {ya, xa};
            rx = xa ? pixel_x - WS : pixel_x;
            ry = ya ? pixel_y - HS : pixel_y;
            oob = {1'b0, pixel_x} >= W2 || {1'b0, pixel_y} >= H2 || int'(rc) >= N_CH;
        end
        oob = oob || int'(sel) >= N_CH;
    end

    logic [AW-1:0] ra;
    logic          f1, f2, v1;

    // Border flags reset high so the output shows BORDER until real data arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ra <= '0;
            f1 <= 1'b1;
            f2 <= 1'b1;
            v1 <= 1'b0;
            pixel_valid <= 1'b0;
        end else begin
            ra <= addr(rc, rx, ry);
            f1 <= oob;
            f2 <= f1;
            v1 <= rd_en;
            pixel_valid <= v1;
        end
    end

    assign pixel_val = f2 ? BORDER : q;

    sdp_ram_1clk #(.DEPTH(N_CH * W * H), .AW(AW), .DW(PIX_W)) u_ram (
        .clk (clk),
        .we  (we),
        .wa  (addr(gnt, gx, gy)),
        .wd  (gd),
        .ra  (ra),
        .q   (q)
    );

`ifdef VGA_DBG_STATS_EN
    logic [DROP_W-1:0] drop [N_CH];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) drop[c] <= '0;
        end else begin
            for (int c = 0; c < N_CH; c++)
                if (gnt_v && !in_img && gnt == 2'(c) && drop[c] != '1) drop[c] <= drop[c] + 1'b1;
        end
    end
    for (genvar g = 0; g < N_CH; g++) begin : g_drop
        assign drop_cnt[g*DROP_W +: DROP_W] = drop[g];
    end
`endif
endmodule

// File: tb/tb_vga_multi_debug.sv
// tb_vga_multi_debug: randomized self-checking bench against a frame-store reference model.
module tb_vga_multi_debug;
    localparam int NCH = 2, W = 4, H = 2, PW = 8, XW = 10;
    localparam logic [7:0] BRD = 8'hEE;

    logic clk = 1'b0, reset = 1'b1;
    logic [NCH-1:0] in_valid = '0, in_ready;
    logic [NCH*XW-1:0] in_x = '0, in_y = '0;
    logic [NCH*PW-1:0] in_val = '0;
    logic rd_en = 1'b0;
    logic [XW-1:0] pixel_x = '0, pixel_y = '0;
    logic [1:0] mode = '0, sel = '0;
    logic pixel_valid;
    logic [PW-1:0] pixel_val;
`ifdef VGA_DBG_STATS_EN
    logic [NCH*16-1:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    vga_multi_debug #(.N_CH(NCH), .W(W), .H(H), .PIX_W(PW), .XY_W(XW), .BORDER(BRD)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_val(in_val), .rd_en(rd_en),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .mode(mode), .sel(sel),
        .pixel_valid(pixel_valid), .pixel_val(pixel_val)
`ifdef VGA_DBG_STATS_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    int n_cmp = 0, n_bad = 0;
    logic [7:0] mem_m [4][H][W];
    int drops_m [4] = '{0, 0, 0, 0};
    bit pv [2] = '{0, 0};
    logic [7:0] pe [2];
    bit exp_v;
    logic [7:0] exp_d;

    // Reference view mapping straight from the display rules.
    function automatic logic [7:0] ref_read(int x, int y, int md, int s);
        int c;
        if (md == 3 || s >= NCH) return BRD;
        if (md == 0) return (x < W && y < H) ? mem_m[s][y][x] : BRD;
        if (md == 1) begin
            if (y >= H || x >= 2 * W) return BRD;
            return x < W ? mem_m[s][y][x] : mem_m[(s + 1) % NCH][y][x - W];
        end
        c = (y >= H ? 2 : 0) + (x >= W ? 1 : 0);
        if (x >= 2 * W || y >= 2 * H || c >= NCH) return BRD;
        return mem_m[c][y % H][x % W];
    endfunction

    // Drives one read slot; exp_v/exp_d then hold what the outputs must show now.
    task automatic rd_step(bit en, int x, int y, int md, int s);
        @(negedge clk);
        exp_v = pv[1];
        exp_d = pe[1];
        pv[1] = pv[0];
        pe[1] = pe[0];
        rd_en = en;
        pixel_x = XW'(x);
        pixel_y = XW'(y);
        mode = 2'(md);
        sel = 2'(s);
        pv[0] = en;
        pe[0] = ref_read(x, y, md, s);
    endtask

    task automatic send(int c, int x, int y, logic [7:0] v);
        int k = 0;
        @(negedge clk);
        in_valid[c] = 1'b1;
        in_x[c*XW +: XW] = XW'(x);
        in_y[c*XW +: XW] = XW'(y);
        in_val[c*PW +: PW] = v;
        while (!in_ready[c] && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout ch%0d: in_ready stayed 0, required 1", c);
        end else if (x < W && y < H) mem_m[c][y][x] = v;
        else drops_m[c]++;
        @(negedge clk);
        in_valid[c] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 2'b11) begin n_bad++; $display("FAIL rst_ready got %b required 11", in_ready); end
        n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b required 0", pixel_valid); end
        n_cmp++; if (pixel_val !== BRD) begin n_bad++; $display("FAIL rst_val got %h required %h", pixel_val, BRD); end
`ifdef VGA_DBG_STATS_EN
        n_cmp++; if (drop_cnt !== '0) begin n_bad++; $display("FAIL rst_drop got %h required 0", drop_cnt); end
`endif
        reset = 1'b0;
    endtask

    task automatic test_init();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                for (int c = 0; c < NCH; c++) send(c, x, y, 8'($urandom));
        repeat (3) @(negedge clk);
    endtask

    task automatic test_capture_pair();
        @(negedge clk);
        in_valid = 2'b11;
        in_x = {10'd1, 10'd1};
        in_y = {10'd1, 10'd1};
        in_val = {8'hAA, 8'h55};
        n_cmp++; if (in_ready !== 2'b11) begin n_bad++; $display("FAIL pair_ready got %b required 11", in_ready); end
        mem_m[0][1][1] = 8'h55;
        mem_m[1][1][1] = 8'hAA;
        @(negedge clk);
        in_valid = 2'b00;
        n_cmp++; if (in_ready !== 2'b00) begin n_bad++; $display("FAIL pair_held got %b required 00", in_ready); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 2'b01) begin n_bad++; $display("FAIL rr_first got %b required 01", in_ready); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 2'b11) begin n_bad++; $display("FAIL rr_second got %b required 11", in_ready); end
    endtask

    task automatic test_modes();
        int tbl [8][4] = '{'{0,1,1,1}, '{1,0,5,1}, '{1,0,8,1}, '{2,0,1,3},
                           '{2,0,5,1}, '{3,0,0,0}, '{1,1,5,0}, '{0,0,4,0}};
        for (int i = 0; i < 10; i++) begin
            if (i < 8) rd_step(1'b1, tbl[i][2], tbl[i][3], tbl[i][0], tbl[i][1]);
            else rd_step(1'b0, 0, 0, 0, 0);
            n_cmp++; if (pixel_valid !== exp_v) begin n_bad++; $display("FAIL modes_valid[%0d] got %b required %b", i, pixel_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (pixel_val !== exp_d) begin n_bad++; $display("FAIL modes_val[%0d] got %h required %h", i, pixel_val, exp_d); end
            end
        end
    endtask

    task automatic test_throughput();
        int acc0 = 0, acc1 = 0;
        logic [7:0] v0, v1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            v0 = 8'($urandom);
            in_valid[0] = 1'b1;
            in_x[0 +: XW] = 10'd2;
            in_y[0 +: XW] = 10'd0;
            in_val[0 +: PW] = v0;
            n_cmp++; if (in_ready[0] !== (i % 2 == 0)) begin n_bad++; $display("FAIL solo_ready[%0d] got %b required %b", i, in_ready[0], i % 2 == 0); end
            if (in_ready[0]) begin acc0++; mem_m[0][0][2] = v0; end
        end
        @(negedge clk);
        in_valid = '0;
        n_cmp++; if (acc0 != 5) begin n_bad++; $display("FAIL solo_count got %0d required 5", acc0); end
        repeat (2) @(negedge clk);
        acc0 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            v0 = 8'($urandom);
            v1 = 8'($urandom);
            in_valid = 2'b11;
            in_x = {10'd2, 10'd3};
            in_y = {10'd1, 10'd0};
            in_val = {v1, v0};
            if (in_ready[0]) begin acc0++; mem_m[0][0][3] = v0; end
            if (in_ready[1]) begin acc1++; mem_m[1][1][2] = v1; end
        end
        @(negedge clk);
        in_valid = '0;
        n_cmp++; if (acc0 != 5) begin n_bad++; $display("FAIL fair_ch0 got %0d required 5", acc0); end
        n_cmp++; if (acc1 != 5) begin n_bad++; $display("FAIL fair_ch1 got %0d required 5", acc1); end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i < 3) rd_step(1'b1, i == 2 ? 2 : 2 + i, i == 2 ? 1 : 0, 0, i == 2 ? 1 : 0);
            else rd_step(1'b0, 0, 0, 0, 0);
            n_cmp++; if (pixel_valid !== exp_v) begin n_bad++; $display("FAIL thr_valid[%0d] got %b required %b", i, pixel_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (pixel_val !== exp_d) begin n_bad++; $display("FAIL thr_val[%0d] got %h required %h", i, pixel_val, exp_d); end
            end
        end
    endtask

    task automatic test_drop();
        send(0, 7, 0, 8'h33);
        send(0, 0, 2, 8'h44);
        repeat (2) @(negedge clk);
`ifdef VGA_DBG_STATS_EN
        n_cmp++; if (drop_cnt[15:0] !== 16'(drops_m[0])) begin n_bad++; $display("FAIL drop_ch0 got %0d required %0d", drop_cnt[15:0], drops_m[0]); end
        n_cmp++; if (drop_cnt[31:16] !== 16'(drops_m[1])) begin n_bad++; $display("FAIL drop_ch1 got %0d required %0d", drop_cnt[31:16], drops_m[1]); end
`endif
        for (int i = 0; i < 4; i++) begin
            if (i < 2) rd_step(1'b1, i == 0 ? 3 : 0, i == 0 ? 1 : 0, 0, i);
            else rd_step(1'b0, 0, 0, 0, 0);
            n_cmp++; if (pixel_valid !== exp_v) begin n_bad++; $display("FAIL drop_rd_valid[%0d] got %b required %b", i, pixel_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (pixel_val !== exp_d) begin n_bad++; $display("FAIL drop_rd_val[%0d] got %h required %h", i, pixel_val, exp_d); end
            end
        end
    endtask

    task automatic test_random_reads();
        for (int i = 0; i < 152; i++) begin
            if (i < 150) rd_step($urandom_range(0, 3) != 0, int'($urandom_range(0, 2 * W + 1)),
                                 int'($urandom_range(0, 2 * H + 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            else rd_step(1'b0, 0, 0, 0, 0);
            n_cmp++; if (pixel_valid !== exp_v) begin n_bad++; $display("FAIL rand_valid[%0d] got %b required %b", i, pixel_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (pixel_val !== exp_d) begin n_bad++; $display("FAIL rand_val[%0d] got %h required %h", i, pixel_val, exp_d); end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 26; i++) begin
            if (i < 24) rd_step(1'b1, int'($urandom_range(0, 2 * W - 1)), int'($urandom_range(0, H - 1)), 1, int'($urandom_range(0, 1)));
            else rd_step(1'b0, 0, 0, 0, 0);
            n_cmp++; if (pixel_valid !== exp_v) begin n_bad++; $display("FAIL b2b_valid[%0d] got %b required %b", i, pixel_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (pixel_val !== exp_d) begin n_bad++; $display("FAIL b2b_val[%0d] got %h required %h", i, pixel_val, exp_d); end
            end
        end
    endtask

    task automatic test_reset_flight();
        rd_step(1'b1, 1, 1, 0, 0);
        rd_step(1'b1, 1, 1, 0, 1);
        @(negedge clk);
        n_cmp++; if (pixel_valid !== 1'b1) begin n_bad++; $display("FAIL flight_valid got %b required 1", pixel_valid); end
        rd_en = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL flight_rst_valid got %b required 0", pixel_valid); end
        n_cmp++; if (pixel_val !== BRD) begin n_bad++; $display("FAIL flight_rst_val got %h required %h", pixel_val, BRD); end
        @(negedge clk);
        reset = 1'b0;
        pv = '{0, 0};
        @(negedge clk);
        n_cmp++; if (pixel_valid !== 1'b0) begin n_bad++; $display("FAIL post_rst_idle got %b required 0", pixel_valid); end
        for (int i = 0; i < 3; i++) begin
            if (i == 0) rd_step(1'b1, 1, 1, 0, 0);
            else rd_step(1'b0, 0, 0, 0, 0);
            n_cmp++; if (pixel_valid !== exp_v) begin n_bad++; $display("FAIL post_rst_valid[%0d] got %b required %b", i, pixel_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (pixel_val !== exp_d) begin n_bad++; $display("FAIL post_rst_val[%0d] got %h required %h", i, pixel_val, exp_d); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_capture_pair();
        test_modes();
        test_throughput();
        test_drop();
        test_random_reads();
        test_back_to_back();
        test_reset_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_multi_debug.md
# vga_multi_debug

Single-clock, multi-channel debug frame buffer for the stereo pipeline. It captures up to N_CH pixel streams (left, right, disparity, …) into one shared on-chip frame store, one region per channel. It serves display reads with a fixed 2-cycle latency in one of three view modes: single, side-by-side or 2×2 tile. It sits between the stereo processing stages and the VGA controller and replaces the single-stream debug buffer.

## Interface
- N_CH, 2: number of input channels (1–4)
- W, 320: frame width in pixels per channel
- H, 240: frame height in pixels per channel
- PIX_W, 8: pixel width
- XY_W, 10: coordinate width
- BORDER, 0: pixel value returned for any location outside valid image data
- clk  in  1  single clock for capture and display reads
- reset  in  1  asynchronous, active-high
- in_valid  in  N_CH  per-channel pixel valid
- in_ready  out  N_CH  per-channel ready; a transfer occurs when valid&ready
- in_x, in_y  in  N_CH*XY_W each  per-channel pixel coordinates, channel c in bits [c*XY_W +: XY_W]
- in_val  in  N_CH*PIX_W  per-channel pixel data
- rd_en  in  1  display read request
- pixel_x, pixel_y  in  XY_W each  display coordinates
- mode  in  2  view mode: 0 SINGLE, 1 SIDE, 2 TILE, 3 reserved
- sel  in  2  base channel for SINGLE/SIDE
- pixel_valid  out  1  read data valid
- pixel_val  out  PIX_W  read data
- drop_cnt  out  N_CH*16  per-channel discarded-pixel counters (only with VGA_DBG_STATS_EN)

## Operation
- Capture side:
  - Each channel has a 1-deep holding register, and in_ready[c] = ~hold_valid[c].
  - A round-robin arbiter grants one held channel per cycle, starting the search at the channel after the last grant.
  - The granted pixel is written at addr = c*W*H + y*W + x. ADDR_W = clog2(N_CH*W*H), and the multiplies are unsigned at ADDR_W.
  - Held pixels with x>=W or y>=H are consumed (hold cleared) without a RAM write.
  - A channel's hold register is cleared on the cycle it is granted. A new accept on the same cycle is not permitted, because ready is registered from hold.
- Read mapping, evaluated on the sampled pixel_x/pixel_y/mode/sel:
  - SINGLE: channel sel, coordinates (x,y). Out of range if x>=W or y>=H.
  - SIDE: if x<W, channel sel at (x,y); if W<=x<2W, channel (sel+1) mod N_CH at (x-W,y). Otherwise out of range.
  - TILE: channel = (y>=H)*2 + (x>=W), coordinates reduced modulo W/H. Out of range if x>=2W, y>=2H, or channel>=N_CH.
  - mode 3, or sel>=N_CH: always BORDER.
- Out-of-range locations return BORDER.
- Read-during-write to the same address returns the old data.

## Timing
- Read latency is exactly 2 cycles:
  - Edge 1 registers the address and border flag.
  - Edge 2 registers the RAM output and the delayed flag and valid.
  - pixel_val = flag_d2 ? BORDER : q.
- One read is accepted per cycle, back-to-back at full rate. pixel_valid tracks rd_en delayed by 2 cycles.
- Capture throughput is 1 pixel/cycle aggregate. A single always-valid channel sustains 1 pixel per 2 cycles.
- Reset values:
  - in_ready all 1; hold_valid 0; arbiter pointer 0.
  - pixel_valid 0; border flags 1, so pixel_val = BORDER.
  - drop_cnt 0.
- Reset mid-operation discards held pixels and in-flight reads, and RAM contents are retained. The first read after reset release returns stored data.

## Configuration
- VGA_DBG_STATS_EN defined:
  - drop_cnt exists. drop_cnt[c] increments on each out-of-range pixel consumed from channel c.
  - The counter saturates at 16'hFFFF.
- Undefined: the drop_cnt port and counters are absent, and behaviour is otherwise identical.

## Structure
- Package vga_debug_pkg holds:
  - the mode encodings (MODE_SINGLE, MODE_SIDE, MODE_TILE);
  - the drop counter width, 16;
  - the ADDR_W computation function.
- Sub-module sdp_ram_1clk:
  - simple dual-port RAM, depth N_CH*W*H × PIX_W;
  - one write port, one registered read port;
  - old-data read-during-write.
- Arbiter and mapping logic stay in the top module.

## Test plan
- Reset, then N_CH=2, W=4, H=2. Write ch0 (1,1)=0x55 and ch1 (1,1)=0xAA together → both accepted. Both writes land within 2 cycles in round-robin order, ch0 first. A SINGLE read of (1,1) with sel=1 returns 0xAA exactly 2 cycles after rd_en.
- SIDE mode, sel=0, read x=5,y=1 → ch1 (1,1) = 0xAA. Read x=8 → BORDER.
- TILE mode, N_CH=2, read (1,3) → BORDER, because channel 2 is absent. Read (5,1) → ch1 data.
- ch0 in_valid held high for 10 cycles → in_ready toggles 1,0. Exactly 5 writes occur, and the arbiter alternates fairly when ch1 is also held valid.
- Write ch0 x=7 (out of range) with VGA_DBG_STATS_EN → no RAM change; drop_cnt[0]=1. Without the macro → no RAM change.
- Assert reset while 2 reads are in flight → pixel_valid drops immediately and pixel_val=BORDER. After release, the RAM still holds 0x55.
